// File: rtl/boot_sequencer_if.sv
// Mode-controller bus: programming requests from the board, the UART programmer
// write/done strobes, and the reset/status outputs towards the CPU and display.
interface boot_sequencer_if #(
  parameter int CNT_W = 14
);
  logic             start_pg;
  logic             enter;
  logic             upg_done_i;
  logic             upg_wen_i;
  logic [14:0]      upg_adr_i;
  logic             upg_rst;
  logic             cpu_rst;
  logic             inited;
  logic [2:0]       state;
  logic [CNT_W-1:0] imem_words;
  logic [CNT_W-1:0] dmem_words;
  logic             err;

  modport master (
    output start_pg, enter, upg_done_i, upg_wen_i, upg_adr_i,
    input  upg_rst, cpu_rst, inited, state, imem_words, dmem_words, err
  );

  modport slave (
    input  start_pg, enter, upg_done_i, upg_wen_i, upg_adr_i,
    output upg_rst, cpu_rst, inited, state, imem_words, dmem_words, err
  );
endinterface

// File: rtl/boot_sequencer.sv
// IDLE/PROG/READY/RUN sequencer that hands memories to the UART programmer or the CPU.
// Optional PROG inactivity timeout enabled by defining BOOT_TIMEOUT_EN.
module boot_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int          CNT_W          = 14
) (
  input  logic             clock,
  input  logic             reset,
  boot_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_READY = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       done_sync_q, wen_sync_q;
  logic             wen_prev_q;
  logic             adr_sel_q;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] imem_q, imem_d, dmem_q, dmem_d;
  logic             sync_done, sync_wen, wr_pulse, enter_prog;
  logic             unused_adr_bits;

  assign sync_done       = done_sync_q[1];
  assign sync_wen        = wen_sync_q[1];
  assign wr_pulse        = sync_wen & ~wen_prev_q;
  assign unused_adr_bits = ^bus.upg_adr_i[13:0];

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      done_sync_q <= 2'b00;
      wen_sync_q  <= 2'b00;
      wen_prev_q  <= 1'b0;
      adr_sel_q   <= 1'b0;
      armed_q     <= 1'b0;
      imem_q      <= '0;
      dmem_q      <= '0;
`ifdef BOOT_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      done_sync_q <= {done_sync_q[0], bus.upg_done_i};
      wen_sync_q  <= {wen_sync_q[0], bus.upg_wen_i};
      wen_prev_q  <= sync_wen;
      // Capture the bank select on the edge where sync_wen rises; the address is stable by then.
      if (wen_sync_q[0] && !wen_sync_q[1])
        adr_sel_q <= bus.upg_adr_i[14];
      armed_q     <= armed_d;
      imem_q      <= imem_d;
      dmem_q      <= dmem_d;
`ifdef BOOT_TIMEOUT_EN
      timer_q     <= timer_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    imem_d     = imem_q;
    dmem_d     = dmem_q;
    enter_prog = 1'b0;
`ifdef BOOT_TIMEOUT_EN
    timer_d    = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_pg)   enter_prog = 1'b1;
        else if (bus.enter) state_d    = S_RUN;
      end
      S_PROG: begin
        if (!sync_done) armed_d = 1'b1;
        if (wr_pulse) begin
          if (adr_sel_q) begin
            if (dmem_q != '1) dmem_d = dmem_q + 1'b1;
          end else begin
            if (imem_q != '1) imem_d = imem_q + 1'b1;
          end
        end
`ifdef BOOT_TIMEOUT_EN
        timer_d = wr_pulse ? 32'd0 : timer_q + 32'd1;
`endif
        // armed blocks a done level that was still high from the previous session.
        if (armed_q && sync_done)
          state_d = S_READY;
`ifdef BOOT_TIMEOUT_EN
        else if (!wr_pulse && timer_q == 32'(TIMEOUT_CYCLES - 1))
          state_d = S_ERR;
`endif
      end
      S_READY: begin
        if (bus.start_pg)   enter_prog = 1'b1;
        else if (bus.enter) state_d    = S_RUN;
      end
      S_RUN, S_ERR: begin
        if (bus.start_pg) enter_prog = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_prog) begin
      state_d = S_PROG;
      armed_d = 1'b0;
      imem_d  = '0;
      dmem_d  = '0;
`ifdef BOOT_TIMEOUT_EN
      timer_d = '0;
`endif
    end
  end

  always_comb begin
    bus.upg_rst = 1'b1;
    bus.cpu_rst = 1'b1;
    bus.inited  = 1'b0;
    case (state_q)
      S_PROG:  bus.upg_rst = 1'b0;
      S_RUN: begin
        bus.cpu_rst = 1'b0;
        bus.inited  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BOOT_TIMEOUT_EN
  assign bus.err = (state_q == S_ERR);
`else
  assign bus.err = 1'b0;
`endif

  assign bus.state      = 3'(state_q);
  assign bus.imem_words = imem_q;
  assign bus.dmem_words = dmem_q;
endmodule
